// File: rtl/cyc_24_pucch1_despread_if.sv
// Sample/result bus of the PUCCH format 1 OCC despreader.
// The driver of samples and group starts uses master; the despreader uses slave.
interface cyc_24_pucch1_despread_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = DATA_W + 4
);
    logic                     i_start;
    logic [2:0]               i_nSF;
    logic [2:0]               i_occi;
    logic                     i_valid;
    logic signed [DATA_W-1:0] i_re;
    logic signed [DATA_W-1:0] i_im;
    logic signed [OUT_W-1:0]  o_re;
    logic signed [OUT_W-1:0]  o_im;
    logic                     o_valid;
    logic                     o_done;
    logic                     o_busy;
    logic                     o_is_supported;

    modport master (
        output i_start, i_nSF, i_occi, i_valid, i_re, i_im,
        input  o_re, o_im, o_valid, o_done, o_busy, o_is_supported
    );

    modport slave (
        input  i_start, i_nSF, i_occi, i_valid, i_re, i_im,
        output o_re, o_im, o_valid, o_done, o_busy, o_is_supported
    );
endinterface

// File: rtl/cyc_24_pucch1_despread.sv
// PUCCH format 1 OCC despreader: de-rotates nSF samples by conj(w_i(m)) and sums them.
// Optional macro CYC24_DESPREAD_SAT_EN clamps the output instead of wrapping it.
//
// state | meaning
// IDLE  | waiting for i_start
// CHECK | evaluating the latched nSF/occi for support
// ACCUM | accepting samples m = 0..nSF-1
// DRAIN | last sample in the two-stage datapath, result pending
module cyc_24_pucch1_despread #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = DATA_W + 4
) (
    input logic clk,
    input logic rst,
    cyc_24_pucch1_despread_if.slave bus
);
    localparam int ACC_W  = DATA_W + 5;
    localparam int PW     = DATA_W + COEF_W + 1;
    localparam int ONE_I  = 1 << (COEF_W - 2);
    localparam int HALF_I = ONE_I / 2;
    localparam int C30_I  = int'(0.8660254037844386 * real'(ONE_I));

    typedef enum logic [1:0] {IDLE, CHECK, ACCUM, DRAIN} state_t;
    state_t state, state_nxt;

    logic [2:0] nsf_q, occi_q, m_q;
    logic [3:0] ph_q, ph_cur, ph_nxt, step, k, idx;
    logic [4:0] ph_sum;
    logic       supported, accept, last, f4;
    logic       s1_vld, s1_last, o_valid_q, o_done_q, sup_q;
    logic signed [COEF_W-1:0] c, s;
    logic signed [PW-1:0]     x_e, y_e, c_e, s_e, pr, pi;
    logic signed [ACC_W-1:0]  rot_re, rot_im, s1_re, s1_im, acc_re, acc_im, sum_re, sum_im;
    logic signed [OUT_W-1:0]  o_re_q, o_im_q, out_re, out_im;

    assign supported = (nsf_q == 3'd1 || nsf_q == 3'd2 || nsf_q == 3'd3 ||
                        nsf_q == 3'd4 || nsf_q == 3'd6) && (occi_q < nsf_q);
    assign accept = (state == ACCUM) && bus.i_valid && !bus.i_start;
    assign last   = accept && (m_q == nsf_q - 3'd1);

    always_comb begin
        state_nxt = state;
        if (bus.i_start) begin
            state_nxt = CHECK;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                CHECK:   state_nxt = supported ? ACCUM : IDLE;
                ACCUM:   if (last) state_nxt = DRAIN;
                DRAIN:   if (o_valid_q) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Phases are kept in half-units (p/2, 0..11); 12/nSF steps per unit of occi*m.
    always_comb begin
        k = 4'd0;
        case (nsf_q)
            3'd1:    k = 4'd12;
            3'd2:    k = 4'd6;
            3'd3:    k = 4'd4;
            3'd4:    k = 4'd3;
            3'd6:    k = 4'd2;
            default: k = 4'd0;
        endcase
        step   = k * {1'b0, occi_q};
        ph_sum = {1'b0, ph_q} + {1'b0, step};
        ph_nxt = (ph_sum >= 5'd12) ? 4'(ph_sum - 5'd12) : ph_sum[3:0];
        f4 = 1'b0;
        case (occi_q)
            3'd1:    f4 = m_q[0];
            3'd2:    f4 = m_q[1];
            3'd3:    f4 = m_q[0] ^ m_q[1];
            default: f4 = 1'b0;
        endcase
        if (nsf_q == 3'd4) ph_cur = f4 ? 4'd6 : 4'd0;
        else               ph_cur = ph_q;
        idx = (ph_cur == 4'd0) ? 4'd0 : 4'd12 - ph_cur;
    end

    always_comb begin
        c = COEF_W'(ONE_I);
        s = '0;
        case (idx)
            4'd1:    begin c = COEF_W'(C30_I);   s = COEF_W'(HALF_I);  end
            4'd2:    begin c = COEF_W'(HALF_I);  s = COEF_W'(C30_I);   end
            4'd3:    begin c = '0;               s = COEF_W'(ONE_I);   end
            4'd4:    begin c = COEF_W'(-HALF_I); s = COEF_W'(C30_I);   end
            4'd5:    begin c = COEF_W'(-C30_I);  s = COEF_W'(HALF_I);  end
            4'd6:    begin c = COEF_W'(-ONE_I);  s = '0;               end
            4'd7:    begin c = COEF_W'(-C30_I);  s = COEF_W'(-HALF_I); end
            4'd8:    begin c = COEF_W'(-HALF_I); s = COEF_W'(-C30_I);  end
            4'd9:    begin c = '0;               s = COEF_W'(-ONE_I);  end
            4'd10:   begin c = COEF_W'(HALF_I);  s = COEF_W'(-C30_I);  end
            4'd11:   begin c = COEF_W'(C30_I);   s = COEF_W'(-HALF_I); end
            default: begin c = COEF_W'(ONE_I);   s = '0;               end
        endcase
        x_e = {{(PW-DATA_W){bus.i_re[DATA_W-1]}}, bus.i_re};
        y_e = {{(PW-DATA_W){bus.i_im[DATA_W-1]}}, bus.i_im};
        c_e = {{(PW-COEF_W){c[COEF_W-1]}}, c};
        s_e = {{(PW-COEF_W){s[COEF_W-1]}}, s};
        pr  = x_e * c_e - y_e * s_e;
        pi  = x_e * s_e + y_e * c_e;
        rot_re = ACC_W'(pr >>> (COEF_W - 2));
        rot_im = ACC_W'(pi >>> (COEF_W - 2));
    end

    assign sum_re = acc_re + s1_re;
    assign sum_im = acc_im + s1_im;

`ifdef CYC24_DESPREAD_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

    function automatic logic signed [OUT_W-1:0] clip(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI)      return OUT_W'(SAT_HI);
        else if (v < SAT_LO) return OUT_W'(SAT_LO);
        else                 return OUT_W'(v);
    endfunction

    assign out_re = clip(sum_re);
    assign out_im = clip(sum_im);
`else
    assign out_re = OUT_W'(sum_re);
    assign out_im = OUT_W'(sum_im);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            nsf_q     <= '0;
            occi_q    <= '0;
            m_q       <= '0;
            ph_q      <= '0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            o_re_q    <= '0;
            o_im_q    <= '0;
            o_valid_q <= 1'b0;
            o_done_q  <= 1'b0;
            sup_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_valid_q <= 1'b0;
            o_done_q  <= 1'b0;
            if (bus.i_start) begin
                nsf_q   <= bus.i_nSF;
                occi_q  <= bus.i_occi;
                m_q     <= '0;
                ph_q    <= '0;
                s1_vld  <= 1'b0;
                s1_last <= 1'b0;
                acc_re  <= '0;
                acc_im  <= '0;
            end else begin
                if (state == CHECK) begin
                    sup_q <= supported;
                    if (!supported) o_done_q <= 1'b1;
                end
                s1_vld  <= accept;
                s1_last <= last;
                if (accept) begin
                    s1_re <= rot_re;
                    s1_im <= rot_im;
                    m_q   <= m_q + 3'd1;
                    ph_q  <= ph_nxt;
                end
                if (s1_vld) begin
                    acc_re <= sum_re;
                    acc_im <= sum_im;
                    if (s1_last) begin
                        o_re_q    <= out_re;
                        o_im_q    <= out_im;
                        o_valid_q <= 1'b1;
                        o_done_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_re           = o_re_q;
    assign bus.o_im           = o_im_q;
    assign bus.o_valid        = o_valid_q;
    assign bus.o_done         = o_done_q;
    assign bus.o_busy         = (state == ACCUM) || (state == DRAIN);
    assign bus.o_is_supported = sup_q;
endmodule

// File: tb/tb_cyc_24_pucch1_despread.sv
// Scoreboard bench for cyc_24_pucch1_despread: directed groups push expected results,
// a negedge monitor pops and compares whenever o_valid or o_done is seen.
module tb_cyc_24_pucch1_despread;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int OUT_W  = DATA_W + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cyc_24_pucch1_despread_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    cyc_24_pucch1_despread #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit rej;
        int at;
        int re_lo, re_hi, im_lo, im_hi;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, want %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.o_valid || bus.o_done)) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(bus.o_valid) + 32'(bus.o_done), 0, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_cycle", cyc, mon_e.at, mon_e.at);
                chk("out_done", bus.o_done, 1, 1);
                if (mon_e.rej) begin
                    chk("rej_valid", bus.o_valid, 0, 0);
                    chk("rej_supported", bus.o_is_supported, 0, 0);
                    chk("rej_busy", bus.o_busy, 0, 0);
                end else begin
                    chk("res_valid", bus.o_valid, 1, 1);
                    chk("res_re", bus.o_re, mon_e.re_lo, mon_e.re_hi);
                    chk("res_im", bus.o_im, mon_e.im_lo, mon_e.im_hi);
                    chk("res_supported", bus.o_is_supported, 1, 1);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Junk i_valid in the start and CHECK cycles must be ignored.
    task automatic start_grp(input int nsf, input int occi);
        tick();
        bus.i_start = 1'b1;
        bus.i_nSF   = 3'(nsf);
        bus.i_occi  = 3'(occi);
        bus.i_valid = 1'b1;
        bus.i_re    = 16'sd1234;
        bus.i_im    = -16'sd1234;
        start_cyc   = cyc;
        tick();
        bus.i_start = 1'b0;
        bus.i_re    = 16'sd999;
    endtask

    task automatic send(input int re, input int im, input int gap, input bit lst,
                        input int rlo = 0, input int rhi = 0, input int ilo = 0, input int ihi = 0);
        repeat (gap + 1) begin
            tick();
            bus.i_valid = 1'b0;
            bus.i_start = 1'b0;
        end
        bus.i_valid = 1'b1;
        bus.i_re    = 16'(re);
        bus.i_im    = 16'(im);
        if (lst) sb.push_back('{rej: 1'b0, at: cyc + 2, re_lo: rlo, re_hi: rhi, im_lo: ilo, im_hi: ihi});
    endtask

    task automatic idle();
        tick();
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0, 0);
            sb.delete();
        end
        tick(2);
    endtask

    task automatic reject(input int nsf, input int occi);
        start_grp(nsf, occi);
        sb.push_back('{rej: 1'b1, at: start_cyc + 2, re_lo: 0, re_hi: 0, im_lo: 0, im_hi: 0});
        chk("rej_busy_check", bus.o_busy, 0, 0);
        idle();
        drain();
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_nSF   = '0;
        bus.i_occi  = '0;
        bus.i_valid = 1'b0;
        bus.i_re    = '0;
        bus.i_im    = '0;
        tick(3);
        chk("rst_o_valid", bus.o_valid, 0, 0);
        chk("rst_o_done", bus.o_done, 0, 0);
        chk("rst_o_busy", bus.o_busy, 0, 0);
        chk("rst_o_sup", bus.o_is_supported, 0, 0);
        chk("rst_o_re", bus.o_re, 0, 0);
        chk("rst_o_im", bus.o_im, 0, 0);
        rst = 1'b0;
        tick(2);

        // nSF=2 occi=1: second sample is negated by the cover code
        start_grp(2, 1);
        send(100, 0, 0, 0);
        send(-100, 0, 0, 1, 200, 200, 0, 0);
        idle(); drain();
        start_grp(2, 1);
        send(100, 0, 0, 0);
        send(100, 0, 0, 1, 0, 0, 0, 0);
        idle(); drain();

        // nSF=4 table rows
        start_grp(4, 3);
        send(50, 7, 0, 0);
        chk("accum_busy", bus.o_busy, 1, 1);
        send(-50, -7, 0, 0);
        send(-50, -7, 0, 0);
        send(50, 7, 0, 1, 200, 200, 28, 28);
        idle(); drain();
        start_grp(4, 1);
        send(50, 7, 0, 0);
        send(-50, -7, 0, 0);
        send(-50, -7, 0, 0);
        send(50, 7, 0, 1, 0, 0, 0, 0);
        idle(); drain();

        // nSF=3 occi=1: 120-degree steps, rounding of the coefficients tolerated
        start_grp(3, 1);
        send(1000, 0, 0, 0);
        send(-500, 866, 1, 0);
        send(-500, -866, 0, 1, 2996, 3000, -3, 3);
        idle(); drain();

        reject(5, 0);
        reject(7, 0);
        reject(6, 6);

        // nSF=6 occi=0 with random gaps
        start_grp(6, 0);
        for (int i = 0; i < 6; i++)
            send(10, 20, $urandom_range(0, 3), i == 5, 60, 120, 120, 120);
        idle(); drain();

        // group aborted after 3 samples; only the restarted group reports
        start_grp(6, 0);
        for (int i = 0; i < 3; i++) send(10, 20, $urandom_range(0, 2), 0);
        idle();
        start_grp(6, 0);
        for (int i = 0; i < 6; i++)
            send(10, 20, $urandom_range(0, 3), i == 5, 60, 120, 120, 120);
        idle(); drain();

        // new i_start in the same cycle as o_valid
        start_grp(1, 0);
        send(5, -3, 0, 1, 5, 5, -3, -3);
        idle();
        start_grp(1, 0);
        send(7, 7, 0, 1, 7, 7, 7, 7);
        idle(); drain();

        // async reset in the middle of an nSF=4 group
        start_grp(4, 0);
        send(30, 30, 0, 0);
        send(30, 30, 0, 0);
        idle();
        rst = 1'b1;
        #1;
        chk("mid_rst_o_valid", bus.o_valid, 0, 0);
        chk("mid_rst_o_done", bus.o_done, 0, 0);
        chk("mid_rst_o_busy", bus.o_busy, 0, 0);
        chk("mid_rst_o_sup", bus.o_is_supported, 0, 0);
        chk("mid_rst_o_re", bus.o_re, 0, 0);
        chk("mid_rst_o_im", bus.o_im, 0, 0);
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send(40, 40, 0, 0);
        idle();
        tick(8);
        chk("post_rst_busy", bus.o_busy, 0, 0);
        chk("post_rst_re", bus.o_re, 0, 0);

        drain();
        chk("queue_empty", sb.size(), 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
